matrix_receiver: RTL and testbench

- Receive-side counterpart of the matrix UART transmitter.
- Consumes the byte stream from the UART RX core: N rows, each of N data bytes separated by 0x20, terminated by 0x0D 0x0A.
- Writes each data byte into a frame buffer at a linear address.
- Checks framing positionally, so a data byte whose value is 0x20, 0x0D or 0x0A is still treated as data.

---
 rtl/matrix_uart_pkg.sv | 24 ++
 rtl/matrix_receiver.sv | 150 +++++++++++++++
 tb/tb_matrix_receiver.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_uart_pkg.sv
// Shared types and constants for the matrix UART transmitter/receiver pair.
// The transmitter's special characters live here so both directions agree.
package matrix_uart_pkg;

    localparam int unsigned NB_W   = 15;
    localparam int unsigned CNT_W  = 17;
    localparam int unsigned LINE_W = 8;
    localparam int unsigned MAX_N  = 256;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DATA   = 3'd1,
        SEP    = 3'd2,
        CR     = 3'd3,
        LF     = 3'd4,
        RESYNC = 3'd5,
        DONE   = 3'd6
    } rx_state_e;

endpackage

// File: rtl/matrix_receiver.sv
// Receives an N x N byte matrix from a UART RX stream into a linear frame buffer.
// Optional FRAME_CHECK_EN checks separator/CR/LF values and resyncs on the next LF.
module matrix_receiver
    import matrix_uart_pkg::*;
(
    input  logic              system_clock,
    input  logic              rst_n,
    input  logic              clock_enable,
    input  logic              start,
    input  logic [NB_W-1:0]   num_bytes,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              wr_en,
    output logic [CNT_W-1:0]  wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              frame_error,
    output logic [CNT_W-1:0]  data_counter,
    output logic [LINE_W-1:0] line_counter
);

    localparam logic [NB_W-1:0] MAX_N_W = NB_W'(MAX_N);

    rx_state_e        r_state;
    rx_state_e        w_next_state;
    logic [NB_W-1:0]  r_num;
    logic [NB_W-1:0]  r_col;
    logic [CNT_W-1:0] r_row_base;
    logic             w_rx_ready;
    logic             w_accept;
    logic             w_byte_ok;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_row_end;
    logic             w_bad_frame;

    // State register
    always_ff @(posedge system_clock) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else if (clock_enable) begin
            r_state <= w_next_state;
        end
    end

    // Combinational outputs: readiness and framing decode
    always_comb begin
        w_rx_ready = 1'b0;
        case (r_state)
            DATA, SEP, CR, LF, RESYNC: w_rx_ready = 1'b1;
            default:                   w_rx_ready = 1'b0;
        endcase
    end

    always_comb begin
        w_byte_ok = 1'b1;
`ifdef FRAME_CHECK_EN
        case (r_state)
            SEP:     w_byte_ok = (rx_data == CHAR_SPACE);
            CR:      w_byte_ok = (rx_data == CHAR_CR);
            LF:      w_byte_ok = (rx_data == CHAR_LF);
            default: w_byte_ok = 1'b1;
        endcase
`endif
    end

    assign rx_ready    = w_rx_ready;
    assign w_accept    = rx_valid && w_rx_ready && clock_enable;
    assign w_last_col  = !(r_col < (r_num - NB_W'(1)));
    assign w_last_row  = ((NB_W'(line_counter) + NB_W'(1)) == r_num);
    assign w_bad_frame = w_accept && !w_byte_ok && (r_state inside {SEP, CR, LF});
    assign w_row_end   = w_accept &&
                         (((r_state == LF) && w_byte_ok) ||
                          ((r_state == RESYNC) && (rx_data == CHAR_LF)));

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if ((num_bytes == '0) || (num_bytes > MAX_N_W)) w_next_state = DONE;
                    else                                            w_next_state = DATA;
                end
            end
            DATA:   if (w_accept) w_next_state = w_last_col ? CR : SEP;
            SEP:    if (w_accept) w_next_state = w_byte_ok ? DATA : RESYNC;
            CR:     if (w_accept) w_next_state = w_byte_ok ? LF : RESYNC;
            LF: begin
                if (w_accept) begin
                    if (!w_byte_ok)      w_next_state = RESYNC;
                    else if (w_last_row) w_next_state = DONE;
                    else                 w_next_state = DATA;
                end
            end
            RESYNC: if (w_row_end) w_next_state = w_last_row ? DONE : DATA;
            DONE:   w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Registered outputs, counters and write port
    always_ff @(posedge system_clock) begin
        if (!rst_n) begin
            r_num        <= '0;
            r_col        <= '0;
            r_row_base   <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            frame_error  <= 1'b0;
            data_counter <= '0;
            line_counter <= '0;
        end else if (clock_enable) begin
            wr_en <= 1'b0;
            done  <= (w_next_state == DONE);
            busy  <= (w_next_state inside {DATA, SEP, CR, LF, RESYNC});
            if ((r_state == IDLE) && start) begin
                r_num        <= num_bytes;
                r_col        <= '0;
                r_row_base   <= '0;
                data_counter <= '0;
                line_counter <= '0;
                frame_error  <= (num_bytes > MAX_N_W);
            end
            if ((r_state == DATA) && w_accept) begin
                wr_en        <= 1'b1;
                wr_addr      <= data_counter;
                wr_data      <= rx_data;
                data_counter <= data_counter + CNT_W'(1);
                r_col        <= r_col + NB_W'(1);
            end
            if (w_bad_frame) begin
                frame_error <= 1'b1;
            end
            // Row end also realigns data_counter after a resync skipped bytes
            if (w_row_end) begin
                r_col        <= '0;
                line_counter <= line_counter + LINE_W'(1);
                r_row_base   <= r_row_base + CNT_W'(r_num);
                data_counter <= r_row_base + CNT_W'(r_num);
            end
        end
    end

endmodule

// File: tb/tb_matrix_receiver.sv
// Self-checking bench for matrix_receiver: directed and random frames against a
// frame-level model of expected buffer writes and final counters.
module tb_matrix_receiver;

    logic        system_clock = 1'b0;
    logic        rst_n;
    logic        clock_enable;
    logic        start;
    logic [14:0] num_bytes;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        frame_error;
    logic [16:0] data_counter;
    logic [7:0]  line_counter;

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          ce_mode  = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    logic [24:0] wq[$];
    logic [7:0]  fdata[0:63];

    matrix_receiver dut (
        .system_clock (system_clock),
        .rst_n        (rst_n),
        .clock_enable (clock_enable),
        .start        (start),
        .num_bytes    (num_bytes),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .frame_error  (frame_error),
        .data_counter (data_counter),
        .line_counter (line_counter)
    );

    always #5 system_clock = ~system_clock;

    // A write or done pulse counts once, at the enabled edge that retires it
    always @(negedge system_clock) begin
        if (rst_n && clock_enable) begin
            if (wr_en) wq.push_back({wr_addr, wr_data});
            if (done)  done_cnt++;
        end
    end

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(output logic en, output logic acc);
        case (ce_mode)
            0:       clock_enable = 1'b1;
            1:       clock_enable = ((cyc % 4) == 0);
            default: clock_enable = 1'($urandom_range(0, 1));
        endcase
        cyc++;
        @(negedge system_clock);
        en  = clock_enable;
        acc = rx_valid && rx_ready && clock_enable && rst_n;
        @(posedge system_clock);
        #1;
    endtask

    task automatic send_frame(input int n, input int crow, input int cpos);
        logic [7:0]  bytes[$];
        logic        is_data[$];
        logic [24:0] exp_w[$];
        logic        en, acc, got, legal, chk_on;
        int          wbase, dbase, addr, ncols;
`ifdef FRAME_CHECK_EN
        chk_on = 1'b1;
`else
        chk_on = 1'b0;
`endif
        legal = (n >= 1) && (n <= 256);
        // Model: which cells land in the buffer, and the byte stream to send
        if (legal) begin
            for (int r = 0; r < n; r++) begin
                ncols = n;
                if (chk_on && r == crow) ncols = (cpos < n - 1) ? cpos + 1 : n;
                for (int c = 0; c < ncols; c++)
                    exp_w.push_back({17'(r * n + c), fdata[r * n + c]});
                for (int c = 0; c < n; c++) begin
                    bytes.push_back(fdata[r * n + c]);
                    is_data.push_back(1'b1);
                    if (c < n - 1) begin
                        bytes.push_back((r == crow && c == cpos) ? 8'h41 : 8'h20);
                        is_data.push_back(1'b0);
                    end
                end
                bytes.push_back((r == crow && cpos == n - 1) ? 8'h41 : 8'h0D);
                is_data.push_back(1'b0);
                bytes.push_back(8'h0A);
                is_data.push_back(1'b0);
            end
        end
        wbase = wq.size();
        dbase = done_cnt;
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        for (int i = 0; i < 3; i++) step(en, acc);
        chk_eq("idle_ready", 32'(rx_ready), 32'd0);
        start     = 1'b1;
        num_bytes = 15'(n);
        got       = 1'b0;
        for (int t = 0; t < 64 && !got; t++) begin
            step(en, acc);
            got = en;
        end
        start = 1'b0;
        chk_eq("start_taken", 32'(got), 32'd1);
        if (n == 0 && ce_mode == 0) chk_eq("n0_done_next", 32'(done), 32'd1);
        if (legal) chk_eq("busy_after_start", 32'(busy), 32'd1);
        addr = 0;
        foreach (bytes[i]) begin
            rx_data = bytes[i];
            got     = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                rx_valid = ($urandom_range(0, 7) != 0);
                step(en, acc);
                got = acc;
            end
            if (!got) begin
                chk_eq("accept_timeout", 32'(got), 32'd1);
                break;
            end
            if (is_data[i]) begin
                if (crow < 0 && ce_mode == 0)
                    chk_eq("wr_latency", 32'({wr_en, wr_addr, wr_data}),
                           32'({1'b1, 17'(addr), bytes[i]}));
                addr++;
            end
        end
        rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) step(en, acc);
        chk_eq("wr_count", 32'(wq.size() - wbase), 32'(exp_w.size()));
        foreach (exp_w[i])
            if (wbase + i < wq.size()) chk_eq("wr_entry", 32'(wq[wbase + i]), 32'(exp_w[i]));
        chk_eq("done_pulses", 32'(done_cnt - dbase), 32'd1);
        chk_eq("line_counter", 32'(line_counter), legal ? 32'(n % 256) : 32'd0);
        chk_eq("data_counter", 32'(data_counter), legal ? 32'(n * n) : 32'd0);
        chk_eq("frame_error", 32'(frame_error),
               32'((n > 256) || (legal && chk_on && crow >= 0)));
        chk_eq("busy_end", 32'(busy), 32'd0);
    endtask

    task automatic fill_random(input int n, input int crow, input int cpos);
        for (int i = 0; i < n * n; i++) begin
            case ($urandom_range(0, 5))
                0:       fdata[i] = 8'h20;
                1:       fdata[i] = 8'h0D;
                2:       fdata[i] = 8'h0A;
                default: fdata[i] = 8'($urandom);
            endcase
        end
        // After a bad delimiter the rest of the row must not contain an early LF
        if (crow >= 0)
            for (int c = cpos + 1; c < n; c++)
                if (fdata[crow * n + c] == 8'h0A) fdata[crow * n + c] = 8'h55;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk_eq({tag, "_wr_en"},   32'(wr_en), 32'd0);
        chk_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk_eq({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk_eq({tag, "_busy"},    32'(busy), 32'd0);
        chk_eq({tag, "_done"},    32'(done), 32'd0);
        chk_eq({tag, "_ferr"},    32'(frame_error), 32'd0);
        chk_eq({tag, "_dcnt"},    32'(data_counter), 32'd0);
        chk_eq({tag, "_lcnt"},    32'(line_counter), 32'd0);
        chk_eq({tag, "_ready"},   32'(rx_ready), 32'd0);
    endtask

    task automatic reset_mid_row();
        logic en, acc;
        int   wbase, dbase;
        ce_mode   = 0;
        wbase     = wq.size();
        dbase     = done_cnt;
        start     = 1'b1;
        num_bytes = 15'd3;
        step(en, acc);
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h10;
        step(en, acc);
        rx_data = 8'h20;
        step(en, acc);
        rx_data = 8'h30;
        rst_n   = 1'b0;
        step(en, acc);
        check_zero_outputs("rst_mid");
        rst_n    = 1'b1;
        rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) step(en, acc);
        chk_eq("rst_mid_writes", 32'(wq.size() - wbase), 32'd1);
        chk_eq("rst_mid_no_done", 32'(done_cnt - dbase), 32'd0);
        chk_eq("rst_mid_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic en, acc;
        int   n, crow, cpos;
        rst_n        = 1'b0;
        clock_enable = 1'b0;
        start        = 1'b0;
        num_bytes    = '0;
        rx_valid     = 1'b0;
        rx_data      = '0;
        ce_mode      = 0;
        for (int i = 0; i < 3; i++) step(en, acc);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        fdata[0] = 8'h11; fdata[1] = 8'h22; fdata[2] = 8'h33; fdata[3] = 8'h44;
        send_frame(2, -1, 0);
        fdata[0] = 8'h20; fdata[1] = 8'h0D; fdata[2] = 8'h0A; fdata[3] = 8'h20;
        send_frame(2, -1, 0);
        fdata[0] = 8'h11; fdata[1] = 8'h22; fdata[2] = 8'h33; fdata[3] = 8'h44;
        send_frame(2, 0, 0);
        fdata[0] = 8'h5A;
        send_frame(1, -1, 0);
        send_frame(0, -1, 0);
        send_frame(257, -1, 0);
        ce_mode = 1;
        fill_random(3, -1, 0);
        send_frame(3, -1, 0);

        for (int k = 0; k < 20; k++) begin
            ce_mode = $urandom_range(0, 2);
            n       = $urandom_range(1, 6);
            crow    = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            cpos    = $urandom_range(0, n - 1);
            fill_random(n, crow, cpos);
            send_frame(n, crow, cpos);
        end

        reset_mid_row();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
